fpu_multiplication: RTL and testbench
=====================================

Name: fpu_multiplication

Overview:
- Iterative IEEE-754 single-precision multiplier; companion to the divider in the same FPU datapath.
- Accepts two operands on a start strobe and returns a rounded product with a one-cycle done pulse.
- Uses a shift-add 24x24 mantissa multiply over several cycles. Special operands resolve in one cycle.

Parameters:
- BITS_PER_CYCLE, 1: multiplier bits retired per iteration. Legal values: 1, 2, 4, 8. Iteration count ITERS = 24/BITS_PER_CYCLE.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE; ignored otherwise.
- operand_a  in  32  IEEE-754 single, multiplicand.
- operand_b  in  32  IEEE-754 single, multiplier.
- result  out  32  product. Registered; held stable from done until the next accepted start.
- busy  out  1  high from the edge that accepts start until the edge that asserts done.
- done  out  1  one-cycle registered pulse; result is valid in that cycle.
- flags  out  4  {invalid, overflow, underflow, inexact}. Present only with FPU_MUL_FLAGS_EN.

Behaviour:
- Reset:
  - State becomes IDLE.
  - result=0, busy=0, done=0, flags=0. Internal accumulator and counter are cleared.
  - Reset mid-operation aborts the operation; done is never raised for it.
- States: IDLE -> MULT -> ROUND -> IDLE, with done pulsed on leaving ROUND. The special-operand path goes IDLE -> IDLE with done pulsed.
- IDLE, start=1:
  - Latch the sign sa^sb, the exponents, and the mantissas {1,frac}. Classify both operands.
  - If either operand is special, write result directly and set done=1 on the same edge. Latency is 1 cycle.
  - Otherwise set busy=1, clear the 48-bit product accumulator, set cnt=0, and go to MULT.
- Special-operand priority:
  - Any NaN, or inf*0 (including denormal, which is treated as 0): result 0x7FC00000.
  - Otherwise, inf on either side: {sign, 0xFF, 0}.
  - Otherwise, zero or denormal on either side (flush-to-zero): {sign, 31'b0}.
- MULT:
  - Each edge consumes the BITS_PER_CYCLE LSBs of the multiplier and adds shifted multiples of the multiplicand into the accumulator.
  - After ITERS edges, go to ROUND.
- ROUND (one edge):
  - Exponent is computed in 10-bit signed: e = ea + eb - 127 + p[47].
  - If p[47]=1: mantissa p[46:24], guard p[23], sticky |p[22:0].
  - If p[47]=0: mantissa p[45:23], guard p[22], sticky |p[21:0].
  - Rounding is round-to-nearest-even: increment if guard & (sticky | lsb). A carry out of the mantissa increments e and zeroes the fraction.
  - e >= 255: result {sign, 0xFF, 0}.
  - e <= 0: result {sign, 31'b0}.
  - Else: result {sign, e[7:0], frac}.
  - On this edge: done=1, busy=0.
- Normal latency: ITERS+1 cycles from the accepting edge (25 cycles for BITS_PER_CYCLE=1).
- start while busy or during the done cycle has no effect. Operand inputs may change freely after acceptance.
- done is deasserted on the following edge. Back-to-back start in the cycle after done is accepted.

Optional Feature:
- FPU_MUL_FLAGS_EN defined:
  - flags port exists, registered alongside result.
  - invalid: NaN result produced.
  - overflow: e >= 255 after rounding.
  - underflow: e <= 0 and the product is nonzero.
  - inexact: guard|sticky set, or overflow, or underflow.
  - flags are cleared on reset and on each accepted start.
- FPU_MUL_FLAGS_EN undefined: the flags port and all of its logic are absent. result, busy and done are unchanged.

Decomposition:
- Package fpu_pkg:
  - State enum {IDLE, MULT, ROUND}.
  - Constants EXP_BIAS=127, EXP_MAX=255, FRAC_W=23, MANT_W=24, QNAN=32'h7FC00000.
  - Operand-class typedef {ZERO, NORMAL, INF, NAN}, shared with the divider.
- Sub-module fpu_mul_round: combinational normalize/round/pack of {sign, e, p[47:0]} into result and flags.

Test Plan:
- 0x40400000 * 0x40200000 (3.0*2.5), BITS_PER_CYCLE=1 -> result 0x40F00000, done exactly 25 cycles after acceptance, busy high throughout.
- 0xBFC00000 * 0x3FC00000 -> 0xC0100000. Also 0x3F800001 * 0x3FC00000 (tie case) -> 0x3FC00002, inexact=1.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1, done one cycle after start. 0xFF800000 * 0x3F800000 -> 0xFF800000.
- 0x7F000000 * 0x40000000 -> 0x7F800000, overflow=1. 0x00800000 * 0x00800000 -> 0x00000000, underflow=1.
- start pulsed with new operands at cycle 5 of an operation -> ignored, first result unaffected. rst=1 at cycle 10 -> busy=0 next cycle, no done.
- Repeat the first scenario with BITS_PER_CYCLE=4 -> same result, done after 7 cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the iterative FPU datapath (multiplier and divider).
//   mul_state_t : multiplier sequencer states
//   fp_class_t  : operand classification (denormals fold into ZERO)
//   constants   : IEEE-754 single-precision field widths, bias, canonical quiet NaN
//   classify()  : operand classifier
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    ROUND
  } mul_state_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam int          FRAC_W   = 23;
  localparam int          MANT_W   = 24;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  // A zero exponent is classed as ZERO: denormals are flushed.
  function automatic fp_class_t classify(input logic [31:0] x);
    fp_class_t c;
    if (x[30:23] == 8'h00) begin
      c = ZERO;
    end else if (x[30:23] == 8'hFF) begin
      if (x[22:0] == 23'd0) c = INF;
      else                  c = NAN;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/fpu_mul_round.sv
// fpu_mul_round: combinational normalize, round-to-nearest-even and pack for the
// multiplier. Build macro FPU_MUL_FLAGS_EN adds the exception flag output.
// Ports:
//   sign    in   1  product sign
//   exp_sum in  10  signed ea + eb - bias, before normalization
//   prod    in  48  raw 24x24 mantissa product
//   result  out 32  packed IEEE-754 single
//   flags   out  4  {invalid, overflow, underflow, inexact} (FPU_MUL_FLAGS_EN only)
module fpu_mul_round
  import fpu_pkg::*;
(
  input  logic               sign,
  input  logic signed [9:0]  exp_sum,
  input  logic        [47:0] prod,
  output logic        [31:0] result
`ifdef FPU_MUL_FLAGS_EN
  ,
  output logic        [3:0]  flags
`endif
);

  logic               norm;
  logic        [22:0] mant;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic        [23:0] mant_r;
  logic signed [9:0]  exp_n;
  logic               overflow;
  logic               tiny;

  always_comb begin
    norm = prod[47];
    if (norm) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard & (sticky | mant[0]);
    // A carry into bit 23 leaves the fraction at zero and bumps the exponent.
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    exp_n    = exp_sum + 10'(norm) + 10'(mant_r[23]);
    overflow = (exp_n >= $signed(10'(EXP_MAX)));
    tiny     = (exp_n <= 10'sd0);

    if (overflow) begin
      result = {sign, 8'hFF, 23'd0};
    end else if (tiny) begin
      result = {sign, 31'd0};
    end else begin
      result = {sign, exp_n[7:0], mant_r[FRAC_W-1:0]};
    end
  end

`ifdef FPU_MUL_FLAGS_EN
  logic underflow;

  always_comb begin
    underflow = tiny & (prod != 48'd0);
    flags     = {1'b0, overflow, underflow, guard | sticky | overflow | underflow};
  end
`endif

endmodule

// File: rtl/fpu_multiplication.sv
// fpu_multiplication: iterative IEEE-754 single-precision multiplier using a
// shift-add 24x24 mantissa multiply, BITS_PER_CYCLE multiplier bits per step
// (legal: 1, 2, 4, 8). Special operands resolve on the accepting edge; normal
// operands take ITERS+1 cycles from the accepting edge. Denormals are flushed.
// Build macro FPU_MUL_FLAGS_EN adds the flags output.
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   start      in   1  request, sampled only when idle and not in the done cycle
//   operand_a  in  32  multiplicand
//   operand_b  in  32  multiplier
//   result     out 32  registered product, held until the next accepted start
//   busy       out  1  operation in progress
//   done       out  1  one-cycle pulse, result valid
//   flags      out  4  {invalid, overflow, underflow, inexact} (FPU_MUL_FLAGS_EN only)
//
// state | meaning
// IDLE  | waiting for start; special operands complete here directly
// MULT  | shift-add iterations, ITERS edges
// ROUND | normalize/round/pack, pulse done
module fpu_multiplication
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
`ifdef FPU_MUL_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  localparam int         ITERS    = MANT_W / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

  mul_state_t         state;
  mul_state_t         state_next;
  logic               sign_q;
  logic signed [9:0]  exp_sum_q;
  logic        [47:0] mcand;
  logic        [23:0] mplier;
  logic        [47:0] acc;
  logic        [4:0]  cnt;

  fp_class_t          cls_a;
  fp_class_t          cls_b;
  logic               sign_in;
  logic signed [9:0]  exp_sum_in;
  logic               accept;
  logic               special;
  logic               is_nan;
  logic        [31:0] spec_result;
  logic        [47:0] partial;
  logic        [31:0] rnd_result;

`ifdef FPU_MUL_FLAGS_EN
  logic        [3:0]  rnd_flags;
`endif

  always_comb begin
    cls_a      = classify(operand_a);
    cls_b      = classify(operand_b);
    sign_in    = operand_a[31] ^ operand_b[31];
    exp_sum_in = $signed({2'b00, operand_a[30:23]} + {2'b00, operand_b[30:23]} - 10'(EXP_BIAS));
    // The done cycle is already IDLE, but a start there must not be taken.
    accept     = (state == IDLE) & start & ~done;
    special    = (cls_a != NORMAL) | (cls_b != NORMAL);
    is_nan     = (cls_a == NAN) | (cls_b == NAN) |
                 ((cls_a == INF) & (cls_b == ZERO)) |
                 ((cls_a == ZERO) & (cls_b == INF));
    if (is_nan) begin
      spec_result = QNAN;
    end else if ((cls_a == INF) | (cls_b == INF)) begin
      spec_result = {sign_in, 8'hFF, 23'd0};
    end else begin
      spec_result = {sign_in, 31'd0};
    end
    // mcand is pre-shifted each step, so the low multiplier bits weight it directly.
    partial = mcand * 48'(mplier[BITS_PER_CYCLE-1:0]);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !special) state_next = MULT;
      MULT:    if (cnt == CNT_LAST)    state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  fpu_mul_round u_round (
    .sign    (sign_q),
    .exp_sum (exp_sum_q),
    .prod    (acc),
    .result  (rnd_result)
`ifdef FPU_MUL_FLAGS_EN
    ,
    .flags   (rnd_flags)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result    <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sign_q    <= 1'b0;
      exp_sum_q <= 10'sd0;
      mcand     <= 48'd0;
      mplier    <= 24'd0;
      acc       <= 48'd0;
      cnt       <= 5'd0;
`ifdef FPU_MUL_FLAGS_EN
      flags     <= 4'd0;
`endif
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q    <= sign_in;
            exp_sum_q <= exp_sum_in;
            mcand     <= {24'd0, 1'b1, operand_a[22:0]};
            mplier    <= {1'b1, operand_b[22:0]};
            acc       <= 48'd0;
            cnt       <= 5'd0;
`ifdef FPU_MUL_FLAGS_EN
            flags     <= special ? {is_nan, 3'b000} : 4'd0;
`endif
            if (special) begin
              result <= spec_result;
              done   <= 1'b1;
            end else begin
              busy   <= 1'b1;
            end
          end
        end
        MULT: begin
          acc    <= acc + partial;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + 5'd1;
        end
        ROUND: begin
          result <= rnd_result;
`ifdef FPU_MUL_FLAGS_EN
          flags  <= rnd_flags;
`endif
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_multiplication.sv
// Scoreboard bench for fpu_multiplication: two instances (1 and 4 bits per cycle)
// share reset; each issued vector queues its expected result, flags and latency
// (edges from the accepting edge to the done edge), and a monitor checks every done.
`timescale 1ns/1ps
module tb_fpu_multiplication;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, start4;
  logic [31:0] a1, b1, a4, b4;
  logic [31:0] res1, res4;
  logic        busy1, busy4, done1, done4;
`ifdef FPU_MUL_FLAGS_EN
  logic [3:0]  flg1, flg4;
`endif

  fpu_multiplication #(.BITS_PER_CYCLE(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .operand_a (a1),
    .operand_b (b1),
    .result    (res1),
    .busy      (busy1),
    .done      (done1)
`ifdef FPU_MUL_FLAGS_EN
    ,
    .flags     (flg1)
`endif
  );

  fpu_multiplication #(.BITS_PER_CYCLE(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .operand_a (a4),
    .operand_b (b4),
    .result    (res4),
    .busy      (busy4),
    .done      (done4)
`ifdef FPU_MUL_FLAGS_EN
    ,
    .flags     (flg4)
`endif
  );

  typedef struct {
    int          dut;
    int          id;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   busy_drop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] r;
    logic        b;
    logic [3:0]  f;
    if (done1 || done4) begin
      done_cnt++;
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got done1=%0b done4=%0b at cycle %0d, want none", done1, done4, cyc);
      end else begin
        e = q.pop_front();
        r = (e.dut == 4) ? res4 : res1;
        b = (e.dut == 4) ? busy4 : busy1;
        f = 4'd0;
`ifdef FPU_MUL_FLAGS_EN
        f = (e.dut == 4) ? flg4 : flg1;
`endif
        n_vec++;
        if (r !== e.res) begin
          n_err++;
          $display("FAIL v%0d result: got %08h want %08h", e.id, r, e.res);
        end
        n_vec++;
        if (cyc - e.issue != e.lat) begin
          n_err++;
          $display("FAIL v%0d latency: got %0d want %0d", e.id, cyc - e.issue, e.lat);
        end
        n_vec++;
        if (busy_drop || b !== 1'b0) begin
          n_err++;
          $display("FAIL v%0d busy: dropped_early=%0b busy_at_done=%0b want 0/0", e.id, busy_drop, b);
        end
`ifdef FPU_MUL_FLAGS_EN
        n_vec++;
        if (f !== e.flg) begin
          n_err++;
          $display("FAIL v%0d flags: got %04b want %04b", e.id, f, e.flg);
        end
`else
        if (f !== 4'd0) $display("note v%0d flags unavailable", e.id);
`endif
      end
      busy_drop = 1'b0;
    end else if (q.size() != 0 && cyc >= q[0].issue && q[0].lat > 0) begin
      if (((q[0].dut == 4) ? busy4 : busy1) !== 1'b1) busy_drop = 1'b1;
    end
  end

  task automatic issue(input int dut, input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input int lat, input int hold);
    exp_t e;
    @(negedge clk);
    if (dut == 4) begin a4 = a; b4 = b; start4 = 1'b1; end
    else          begin a1 = a; b1 = b; start1 = 1'b1; end
    e.dut = dut; e.id = id; e.res = er; e.flg = ef; e.lat = lat; e.issue = cyc + 1;
    q.push_back(e);
    repeat (hold) @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    // Operands may change freely once accepted.
    a1 = 32'hDEADBEEF; b1 = 32'h12345678;
    a4 = 32'hDEADBEEF; b4 = 32'h12345678;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!(done1 || done4) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(done1 || done4)) begin
      n_vec++; n_err++;
      $display("FAIL timeout: no done within %0d cycles, %0d pending", budget, q.size());
      q.delete();
    end
  endtask

  task automatic run(input int dut, input int id, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic [3:0] ef, input int lat);
    issue(dut, id, a, b, er, ef, lat, 1);
    wait_done(60);
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    start1 = 1'b0; start4 = 1'b0;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);

    n_vec++;
    if (res1 !== 32'd0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
        res4 !== 32'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got res1=%08h busy1=%0b done1=%0b res4=%08h busy4=%0b done4=%0b want all 0",
               res1, busy1, done1, res4, busy4, done4);
    end
`ifdef FPU_MUL_FLAGS_EN
    n_vec++;
    if (flg1 !== 4'd0 || flg4 !== 4'd0) begin
      n_err++;
      $display("FAIL reset_flags: got %04b/%04b want 0000", flg1, flg4);
    end
`endif
    rst = 1'b0;

    // flags = {invalid, overflow, underflow, inexact}
    run(1,  1, 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 25);
    run(1,  2, 32'hBFC00000, 32'h3FC00000, 32'hC0100000, 4'b0000, 25);
    run(1,  3, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 25);
    run(1,  4, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
    run(1,  5, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 0);
    run(1,  6, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 25);
    run(1,  7, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 25);
    run(1,  8, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0);
    run(1,  9, 32'h00000001, 32'hFF800000, 32'h7FC00000, 4'b1000, 0);
    run(1, 10, 32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 0);
    run(1, 11, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 25);
    run(1, 12, 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001, 25);

    // start held into the done cycle of a special op must not retrigger
    issue(1, 13, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 0, 2);
    repeat (5) @(negedge clk);

    // start mid-operation with different operands is ignored
    issue(1, 14, 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 25, 1);
    repeat (3) @(negedge clk);
    a1 = 32'h3F800000; b1 = 32'h3F800000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(60);

    // reset mid-operation aborts without a done
    @(negedge clk);
    a1 = 32'h40400000; b1 = 32'h40200000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL abort_busy: got %0b want 0", busy1);
    end
    dc = done_cnt;
    repeat (40) @(negedge clk);
    n_vec++;
    if (done_cnt != dc) begin
      n_err++;
      $display("FAIL abort_done: got %0d done pulses want 0", done_cnt - dc);
    end
    run(1, 15, 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 25);

    // four bits per cycle
    run(4, 20, 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 7);
    run(4, 21, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 7);
    run(4, 22, 32'hBFC00000, 32'h3FC00000, 32'hC0100000, 4'b0000, 7);

    repeat (5) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL leftover: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
